// File: rtl/mem_bus_master_if.sv
// Bundle of request, write-stream, read-stream, status and memory-side signals for mem_bus_master.
// The master modport is the initiator's view; the slave modport is the view of the CPU/memory side.
interface mem_bus_master_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  mem_addr_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_in_en;
  logic [DATA_WIDTH-1:0] mem_in;
  logic                  mem_out_en;
  logic [DATA_WIDTH-1:0] mem_out;

  modport master (
    input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data, mem_out,
    output req_ready, wr_ready, rd_valid, rd_data, busy, done, err,
           mem_addr_en, mem_addr, mem_in_en, mem_in, mem_out_en
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len, wr_valid, wr_data, mem_out,
    input  req_ready, wr_ready, rd_valid, rd_data, busy, done, err,
           mem_addr_en, mem_addr, mem_in_en, mem_in, mem_out_en
  );
endinterface

// File: rtl/mem_bus_master.sv
// Single-port memory bus initiator: sequences addr_en / in_en / out_en strobes for word and
// burst transfers, streams write data in and read data out.
//
// state  | meaning
// IDLE   | ready for a request
// ADDR   | present cur_addr with mem_addr_en
// WR     | wait for a write word; mem_in_en follows wr_valid
// RD_EN  | mem_out_en; memory registers the word
// RD_CAP | capture mem_out into rd_data
// DONE   | one-cycle done (and err on write timeout)
module mem_bus_master #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 8,
  parameter int WR_TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst,
  mem_bus_master_if.master bus
);

  localparam int WAIT_W = (WR_TIMEOUT > 1) ? $clog2(WR_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WR_TIMEOUT > 0) ? WR_TIMEOUT - 1 : 0);
  localparam bit TIMEOUT_ON = (WR_TIMEOUT > 0);

  typedef enum logic [2:0] {IDLE, ADDR, WR, RD_EN, RD_CAP, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  is_write;
  logic                  aborted;
  logic [WAIT_W-1:0]     wait_cnt;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cur_addr   <= '0;
      remaining  <= '0;
      is_write   <= 1'b0;
      aborted    <= 1'b0;
      wait_cnt   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cur_addr  <= bus.req_addr;
            remaining <= bus.req_len;
            is_write  <= bus.req_write;
            aborted   <= 1'b0;
            wait_cnt  <= '0;
            state     <= ADDR;
          end
        end
        ADDR: state <= is_write ? WR : RD_EN;
        WR: begin
          if (bus.wr_valid) begin
            wait_cnt <= '0;
            if (remaining == '0) begin
              state <= DONE;
            end else begin
              cur_addr  <= cur_addr + 1'b1;
              remaining <= remaining - 1'b1;
              state     <= ADDR;
            end
          end else if (TIMEOUT_ON && wait_cnt == WAIT_LAST) begin
            // WR_TIMEOUT idle cycles elapsed without a word: abandon the rest of the burst
            aborted <= 1'b1;
            state   <= DONE;
          end else if (TIMEOUT_ON) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RD_EN: state <= RD_CAP;
        RD_CAP: begin
          rd_data_q  <= bus.mem_out;
          rd_valid_q <= 1'b1;
          if (remaining == '0) begin
            state <= DONE;
          end else begin
            cur_addr  <= cur_addr + 1'b1;
            remaining <= remaining - 1'b1;
            state     <= ADDR;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes and status are decoded from the state register only, except the write
  // datapath which passes wr_valid/wr_data straight through while in WR.
  assign bus.req_ready   = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.err         = (state == DONE) && aborted;
  assign bus.wr_ready    = (state == WR);
  assign bus.mem_addr_en = (state == ADDR);
  assign bus.mem_addr    = (state == ADDR) ? cur_addr : '0;
  assign bus.mem_in_en   = (state == WR) && bus.wr_valid;
  assign bus.mem_in      = (state == WR) ? bus.wr_data : '0;
  assign bus.mem_out_en  = (state == RD_EN);
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = rd_data_q;

endmodule
